// File: rtl/legv8_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the LEGv8 datapath.
// Optional memory wait timeout is enabled by defining SEQ_MEM_TIMEOUT_EN.
module legv8_mc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_opCode,
  input  logic [3:0]  i_bCond,
  input  logic        i_Z,
  input  logic        i_N,
  input  logic        i_memReady,
  output logic        o_irWr,
  output logic        o_pcWr,
  output logic [1:0]  o_pcSrc,
  output logic        o_memAddrSel,
  output logic        o_memRd,
  output logic        o_memWr,
  output logic        o_reg2Sel,
  output logic        o_rfWr,
  output logic [1:0]  o_wrDataSel,
  output logic [1:0]  o_SEU,
  output logic        o_ALUSrcB,
  output logic [3:0]  o_ALUOp,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic        o_memErr
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [4:0] {
    InB, InBl, InBcond, InCbz, InCbnz, InAddi, InSubi, InSubis, InAdd, InSub,
    InAnd, InOrr, InLsl, InLsr, InAdds, InSubs, InBr, InStur, InLdur, InIllegal
  } instr_e;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOrr  = 4'd3;
  localparam logic [3:0] AluLsl  = 4'd6;
  localparam logic [3:0] AluLsr  = 4'd7;
  localparam logic [3:0] AluPass = 4'd8;

  state_e state_q, state_d;
  instr_e instr;
  logic   flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic   bcond_taken;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    instr = InIllegal;
    if      (i_opCode == 11'b10001011000) instr = InAdd;
    else if (i_opCode == 11'b11001011000) instr = InSub;
    else if (i_opCode == 11'b10001010000) instr = InAnd;
    else if (i_opCode == 11'b10101010000) instr = InOrr;
    else if (i_opCode == 11'b11010011011) instr = InLsl;
    else if (i_opCode == 11'b11010011010) instr = InLsr;
    else if (i_opCode == 11'b10101011000) instr = InAdds;
    else if (i_opCode == 11'b11101011000) instr = InSubs;
    else if (i_opCode == 11'b11010110000) instr = InBr;
    else if (i_opCode == 11'b11111000000) instr = InStur;
    else if (i_opCode == 11'b11111000010) instr = InLdur;
    else if (i_opCode[10:1] == 10'b1001000100) instr = InAddi;
    else if (i_opCode[10:1] == 10'b1101000100) instr = InSubi;
    else if (i_opCode[10:1] == 10'b1111000100) instr = InSubis;
    else if (i_opCode[10:3] == 8'b01010100) instr = InBcond;
    else if (i_opCode[10:3] == 8'b10110100) instr = InCbz;
    else if (i_opCode[10:3] == 8'b10110101) instr = InCbnz;
    else if (i_opCode[10:5] == 6'b000101) instr = InB;
    else if (i_opCode[10:5] == 6'b100101) instr = InBl;
  end

  // B.cond looks only at the registered flags, never the live ALU flags.
  always_comb begin
    case (i_bCond)
      4'b0000: bcond_taken = flag_z_q;
      4'b0001: bcond_taken = !flag_z_q;
      4'b1010: bcond_taken = !flag_n_q;
      4'b1011: bcond_taken = flag_n_q;
      4'b1100: bcond_taken = !flag_z_q && !flag_n_q;
      4'b1101: bcond_taken = flag_z_q || flag_n_q;
      4'b1110: bcond_taken = 1'b1;
      default: bcond_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;
    o_irWr       = 1'b0;
    o_pcWr       = 1'b0;
    o_pcSrc      = 2'd0;
    o_memAddrSel = 1'b0;
    o_memRd      = 1'b0;
    o_memWr      = 1'b0;
    o_reg2Sel    = 1'b0;
    o_rfWr       = 1'b0;
    o_wrDataSel  = 2'd0;
    o_SEU        = 2'd0;
    o_ALUSrcB    = 1'b0;
    o_ALUOp      = AluAdd;
    o_illegal    = 1'b0;
    o_memErr     = 1'b0;
    o_state      = state_q;
`ifdef SEQ_MEM_TIMEOUT_EN
    cnt_d        = '0;
`endif

    case (state_q)
      StFetch: begin
        o_memRd = 1'b1;
        if (i_memReady) begin
          o_irWr  = 1'b1;
          o_pcWr  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (instr == InIllegal) begin
          o_illegal = 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
        case (instr)
          InAdd, InAdds: o_ALUOp = AluAdd;
          InSub, InSubs: o_ALUOp = AluSub;
          InAnd:         o_ALUOp = AluAnd;
          InOrr:         o_ALUOp = AluOrr;
          InLsl:         o_ALUOp = AluLsl;
          InLsr:         o_ALUOp = AluLsr;
          InAddi: o_ALUSrcB = 1'b1;
          InSubi, InSubis: begin
            o_ALUSrcB = 1'b1;
            o_ALUOp   = AluSub;
          end
          InLdur, InStur: begin
            o_ALUSrcB = 1'b1;
            o_SEU     = 2'd1;
            o_reg2Sel = (instr == InStur);
            state_d   = StMem;
          end
          InB, InBl: begin
            o_SEU   = 2'd2;
            o_pcWr  = 1'b1;
            o_pcSrc = 2'd1;
            // PC already advanced in FETCH, so the link value is PC+4.
            if (instr == InBl) begin
              o_rfWr      = 1'b1;
              o_wrDataSel = 2'd2;
            end
            state_d = StFetch;
          end
          InBr: begin
            o_pcWr  = 1'b1;
            o_pcSrc = 2'd2;
            state_d = StFetch;
          end
          InCbz, InCbnz: begin
            o_SEU     = 2'd3;
            o_reg2Sel = 1'b1;
            o_ALUOp   = AluPass;
            if ((instr == InCbz) == i_Z) begin
              o_pcWr  = 1'b1;
              o_pcSrc = 2'd1;
            end
            state_d = StFetch;
          end
          InBcond: begin
            o_SEU = 2'd3;
            if (bcond_taken) begin
              o_pcWr  = 1'b1;
              o_pcSrc = 2'd1;
            end
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
        if (instr == InSubis || instr == InAdds || instr == InSubs) begin
          flag_z_d = i_Z;
          flag_n_d = i_N;
        end
      end
      StMem: begin
        o_memAddrSel = 1'b1;
        if (instr == InLdur) begin
          o_memRd = 1'b1;
        end else begin
          o_memWr   = 1'b1;
          o_reg2Sel = 1'b1;
        end
        if (i_memReady) state_d = (instr == InLdur) ? StWb : StFetch;
      end
      StWb: begin
        o_rfWr      = 1'b1;
        o_wrDataSel = (instr == InLdur) ? 2'd0 : 2'd1;
        state_d     = StFetch;
      end
      default: state_d = StFetch;
    endcase

`ifdef SEQ_MEM_TIMEOUT_EN
    // Abandon the access on the TIMEOUT_CYCLES-th consecutive wait cycle.
    if ((state_q == StFetch || state_q == StMem) && !i_memReady) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        o_memErr = 1'b1;
        state_d  = StFetch;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    if (i_rst) begin
      o_irWr       = 1'b0;
      o_pcWr       = 1'b0;
      o_pcSrc      = 2'd0;
      o_memAddrSel = 1'b0;
      o_memRd      = 1'b0;
      o_memWr      = 1'b0;
      o_reg2Sel    = 1'b0;
      o_rfWr       = 1'b0;
      o_wrDataSel  = 2'd0;
      o_SEU        = 2'd0;
      o_ALUSrcB    = 1'b0;
      o_ALUOp      = AluAdd;
      o_illegal    = 1'b0;
      o_memErr     = 1'b0;
      o_state      = StFetch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StFetch;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
`ifdef SEQ_MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_legv8_mc_sequencer.sv
// Self-checking bench for legv8_mc_sequencer: a per-instruction model expands each
// directed instruction into its expected per-cycle output vectors.
module tb_legv8_mc_sequencer;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg2_sel;
    logic       rf_wr;
    logic [1:0] wd_sel;
    logic [1:0] seu;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic       illegal;
    logic       mem_err;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  localparam int KB = 0, KBl = 1, KBcond = 2, KCbz = 3, KCbnz = 4, KAddi = 5, KSubi = 6;
  localparam int KSubis = 7, KAdd = 8, KSub = 9, KAnd = 10, KOrr = 11, KLsl = 12, KLsr = 13;
  localparam int KAdds = 14, KSubs = 15, KBr = 16, KStur = 17, KLdur = 18, KIll = 19;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [10:0] i_opCode = '0;
  logic [3:0]  i_bCond = '0;
  logic        i_Z = 1'b0, i_N = 1'b0, i_memReady = 1'b0;
  logic        o_irWr, o_pcWr, o_memAddrSel, o_memRd, o_memWr, o_reg2Sel, o_rfWr;
  logic        o_ALUSrcB, o_illegal, o_memErr;
  logic [1:0]  o_pcSrc, o_wrDataSel, o_SEU;
  logic [3:0]  o_ALUOp;
  logic [2:0]  o_state;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [2:0] state_log[$];
  logic mz = 1'b0, mn = 1'b0;

  legv8_mc_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opCode(i_opCode), .i_bCond(i_bCond), .i_Z(i_Z),
    .i_N(i_N), .i_memReady(i_memReady), .o_irWr(o_irWr), .o_pcWr(o_pcWr),
    .o_pcSrc(o_pcSrc), .o_memAddrSel(o_memAddrSel), .o_memRd(o_memRd),
    .o_memWr(o_memWr), .o_reg2Sel(o_reg2Sel), .o_rfWr(o_rfWr),
    .o_wrDataSel(o_wrDataSel), .o_SEU(o_SEU), .o_ALUSrcB(o_ALUSrcB),
    .o_ALUOp(o_ALUOp), .o_state(o_state), .o_illegal(o_illegal), .o_memErr(o_memErr)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    vec_t act;
    exp_t e;
    act = {o_irWr, o_pcWr, o_pcSrc, o_memAddrSel, o_memRd, o_memWr, o_reg2Sel, o_rfWr,
           o_wrDataSel, o_SEU, o_ALUSrcB, o_ALUOp, o_state, o_illegal, o_memErr};
    state_log.push_back(o_state);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, act, e.v);
      end
    end
  end

  function automatic int kind_of(input logic [10:0] op);
    if (op ==? 11'b000101?????) return KB;
    if (op ==? 11'b100101?????) return KBl;
    if (op ==? 11'b01010100???) return KBcond;
    if (op ==? 11'b10110100???) return KCbz;
    if (op ==? 11'b10110101???) return KCbnz;
    if (op ==? 11'b1001000100?) return KAddi;
    if (op ==? 11'b1101000100?) return KSubi;
    if (op ==? 11'b1111000100?) return KSubis;
    case (op)
      11'b10001011000: return KAdd;
      11'b11001011000: return KSub;
      11'b10001010000: return KAnd;
      11'b10101010000: return KOrr;
      11'b11010011011: return KLsl;
      11'b11010011010: return KLsr;
      11'b10101011000: return KAdds;
      11'b11101011000: return KSubs;
      11'b11010110000: return KBr;
      11'b11111000000: return KStur;
      11'b11111000010: return KLdur;
      default:         return KIll;
    endcase
  endfunction

  function automatic logic cond_holds(input logic [3:0] bc);
    case (bc)
      4'd0:    return mz;
      4'd1:    return !mz;
      4'd10:   return !mn;
      4'd11:   return mn;
      4'd12:   return !mz && !mn;
      4'd13:   return mz || mn;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t exec_exp(input int k, input logic [3:0] bc, input logic z);
    vec_t e;
    logic taken;
    e = '0;
    e.state = 3'd2;
    case (k)
      KSub, KSubs:       e.alu_op = 4'd1;
      KAnd:              e.alu_op = 4'd2;
      KOrr:              e.alu_op = 4'd3;
      KLsl:              e.alu_op = 4'd6;
      KLsr:              e.alu_op = 4'd7;
      KAddi:             e.alu_src_b = 1'b1;
      KSubi, KSubis:     begin e.alu_src_b = 1'b1; e.alu_op = 4'd1; end
      KLdur, KStur:      begin e.alu_src_b = 1'b1; e.seu = 2'd1; e.reg2_sel = (k == KStur); end
      KB, KBl: begin
        e.seu = 2'd2; e.pc_wr = 1'b1; e.pc_src = 2'd1;
        if (k == KBl) begin e.rf_wr = 1'b1; e.wd_sel = 2'd2; end
      end
      KBr:               begin e.pc_wr = 1'b1; e.pc_src = 2'd2; end
      KCbz, KCbnz: begin
        e.seu = 2'd3; e.reg2_sel = 1'b1; e.alu_op = 4'd8;
        taken = (k == KCbz) ? z : !z;
        if (taken) begin e.pc_wr = 1'b1; e.pc_src = 2'd1; end
      end
      KBcond: begin
        e.seu = 2'd3;
        if (cond_holds(bc)) begin e.pc_wr = 1'b1; e.pc_src = 2'd1; end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic vec_t fetch_exp(input logic rdy);
    vec_t e;
    e = '0;
    e.mem_rd = 1'b1;
    e.ir_wr = rdy;
    e.pc_wr = rdy;
    return e;
  endfunction

  task automatic cyc(input vec_t v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  // fw/mw: wait cycles before ready in FETCH/MEM; rst_mem: reset instead of ready in MEM.
  task automatic run(input logic [10:0] op, input logic [3:0] bc, input logic z,
                     input logic n, input int fw, input int mw, input bit rst_mem,
                     input string tag);
    int   k;
    vec_t e;
    k = kind_of(op);
    i_opCode = op;
    i_bCond = bc;
    i_Z = !z;
    i_N = !n;
    for (int i = 0; i <= fw; i++) begin
      i_memReady = (i == fw);
      cyc(fetch_exp(i == fw), {tag, " fetch"});
    end
    i_memReady = 1'b1;
    e = '0;
    e.state = 3'd1;
    e.illegal = (k == KIll);
    cyc(e, {tag, " decode"});
    if (k == KIll) return;
    i_Z = z;
    i_N = n;
    cyc(exec_exp(k, bc, z), {tag, " exec"});
    if (k == KSubis || k == KAdds || k == KSubs) begin mz = z; mn = n; end
    i_Z = !z;
    i_N = !n;
    if (k == KLdur || k == KStur) begin
      for (int i = 0; i <= mw; i++) begin
        if (rst_mem && i == mw) begin
          i_rst = 1'b1;
          i_memReady = 1'b1;
          cyc('0, {tag, " reset in mem"});
          i_rst = 1'b0;
          mz = 1'b0;
          mn = 1'b0;
          return;
        end
        i_memReady = (i == mw);
        e = '0;
        e.state = 3'd3;
        e.addr_sel = 1'b1;
        e.mem_rd = (k == KLdur);
        e.mem_wr = (k == KStur);
        e.reg2_sel = (k == KStur);
        cyc(e, {tag, " mem"});
      end
      i_memReady = 1'b1;
      if (k == KStur) return;
    end else if (k inside {KB, KBl, KBr, KCbz, KCbnz, KBcond}) begin
      return;
    end
    e = '0;
    e.state = 3'd4;
    e.rf_wr = 1'b1;
    e.wd_sel = (k == KLdur) ? 2'd0 : 2'd1;
    cyc(e, {tag, " wb"});
  endtask

  task automatic check_log(input logic [63:0] want, input string tag);
    logic [63:0] got;
    got = '0;
    foreach (state_log[i]) got = (got << 4) | 64'(state_log[i]);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s state trace: got %h required %h", tag, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge i_clk);
    #1;
    i_memReady = 1'b1;
    cyc('0, "reset0");
    cyc('0, "reset1");
    i_rst = 1'b0;

    state_log.delete();
    run(11'b10001011000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ADD");
    check_log(64'h0124, "ADD");
    state_log.delete();
    run(11'b11111000010, 4'd0, 1'b0, 1'b0, 0, 2, 1'b0, "LDUR");
    check_log(64'h0123334, "LDUR");

    run(11'b11110001000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "SUBIS z1");
    state_log.delete();
    run(11'b01010100000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND EQ");
    check_log(64'h012, "BCOND EQ");
    run(11'b11110001001, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "SUBIS z1b");
    run(11'b01010100111, 4'd1, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND NE");
    state_log.delete();
    run(11'b10010101010, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "BL");
    check_log(64'h012, "BL");
    state_log.delete();
    run(11'h000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ILLEGAL");
    check_log(64'h01, "ILLEGAL");

    run(11'b11111000000, 4'd0, 1'b0, 1'b0, 1, 1, 1'b0, "STUR");
    run(11'b00010111111, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "B");
    run(11'b11010110000, 4'd0, 1'b0, 1'b0, 2, 0, 1'b0, "BR");
    run(11'b10110100000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "CBZ z1");
    run(11'b10110100101, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "CBZ z0");
    run(11'b10110101000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "CBNZ z1");
    run(11'b10110101011, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "CBNZ z0");

    run(11'b10101011000, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0, "ADDS n1");
    run(11'b01010100000, 4'd11, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND LT");
    run(11'b01010100000, 4'd10, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND GE");
    run(11'b01010100000, 4'd12, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND GT");
    run(11'b01010100000, 4'd13, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND LE");
    run(11'b11101011000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "SUBS z0n0");
    run(11'b01010100000, 4'd12, 1'b1, 1'b1, 0, 0, 1'b0, "BCOND GT2");
    run(11'b01010100000, 4'd14, 1'b0, 1'b0, 0, 0, 1'b0, "BCOND AL");
    run(11'b01010100000, 4'd15, 1'b1, 1'b1, 0, 0, 1'b0, "BCOND NV");

    run(11'b10010001001, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ADDI");
    run(11'b11010001000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "SUBI");
    run(11'b01010100000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "BCOND EQ noflags");
    run(11'b11001011000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "SUB");
    run(11'b10001010000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "AND");
    run(11'b10101010000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ORR");
    run(11'b11010011011, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "LSL");
    run(11'b11010011010, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "LSR");

    // Reset mid-wait in MEM must also clear the flags.
    run(11'b11110001000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "SUBIS z1c");
    run(11'b11111000010, 4'd0, 1'b0, 1'b0, 0, 1, 1'b1, "LDUR rst");
    run(11'b01010100000, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, "BCOND EQ after rst");

    i_memReady = 1'b0;
    cyc(fetch_exp(1'b0), "fetch wait0");
    cyc(fetch_exp(1'b0), "fetch wait1");
    i_rst = 1'b1;
    cyc('0, "reset in fetch");
    i_rst = 1'b0;
    mz = 1'b0;
    mn = 1'b0;
    state_log.delete();
    run(11'b10001011000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ADD after rst");
    check_log(64'h0124, "ADD after rst");

`ifdef SEQ_MEM_TIMEOUT_EN
    i_memReady = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      vec_t e;
      e = fetch_exp(1'b0);
      e.mem_err = (i == 16);
      cyc(e, "fetch timeout");
    end
    run(11'b10001011000, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, "ADD after timeout");
`endif

    @(posedge i_clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/legv8_mc_sequencer.md
# legv8_mc_sequencer

Multi-cycle control sequencer for the LEGv8 datapath, moving the core from one instruction per cycle to a FETCH/DECODE/EXEC/MEM/WB flow over a single shared instruction/data memory with a ready handshake. It decodes the latched instruction opcode and drives the same datapath controls as the single-cycle control unit, plus IR/PC write strobes and a memory address select. It keeps the Z/N condition flags internally for B.cond.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: memory wait limit; used only with SEQ_MEM_TIMEOUT_EN.

Ports (clock and reset first):
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_opCode  in  11  instr[31:21] from the IR; stable from DECODE onward.
- i_bCond  in  4  instr[3:0] from the IR.
- i_Z, i_N  in  1 each  ALU zero and negative flags; live.
- i_memReady  in  1  memory has completed the current read or write this cycle.
- o_irWr  out  1  load the IR.
- o_pcWr  out  1  load the PC.
- o_pcSrc  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = register Rn.
- o_memAddrSel  out  1  memory address: 0 = PC, 1 = ALU result.
- o_memRd, o_memWr  out  1 each  memory read and write requests.
- o_reg2Sel  out  1  second register operand: 0 = Rm, 1 = Rt.
- o_rfWr  out  1  register file write.
- o_wrDataSel  out  2  RF write data: 0 = memory, 1 = ALU, 2 = PC (link).
- o_SEU  out  2  immediate extension: 0 = I, 1 = D, 2 = B, 3 = CB.
- o_ALUSrcB  out  1  ALU B input: 0 = register, 1 = immediate.
- o_ALUOp  out  4  ALU operation: 0 add, 1 sub, 2 and, 3 orr, 6 lsl, 7 lsr, 8 pass B.
- o_state  out  3  current state, for debug.
- o_illegal  out  1  one-cycle pulse on an undecodable opcode.
- o_memErr  out  1  one-cycle pulse on a memory timeout; tied to 0 when the timeout feature is compiled out.

## Operation
State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Every output is 0 unless the state and instruction below assert it.

Decode table (opcode prefix):
- B = 000101, BL = 100101, B.cond = 01010100, CBZ = 10110100, CBNZ = 10110101.
- ADDI = 1001000100, SUBI = 1101000100, SUBIS = 1111000100.
- ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000.
- LSL = 11010011011, LSR = 11010011010, ADDS = 10101011000, SUBS = 11101011000.
- BR = 11010110000, STUR = 11111000000, LDUR = 11111000010.

States:
- **FETCH**: assert o_memRd with o_memAddrSel = 0. When i_memReady is high, pulse o_irWr and o_pcWr (o_pcSrc = 0), then go to DECODE. Otherwise stay in FETCH.
- **DECODE**: one cycle, for register read. An illegal opcode pulses o_illegal and returns to FETCH. Any other opcode goes to EXEC.
- **EXEC**: drive o_ALUOp, o_ALUSrcB, o_SEU and o_reg2Sel for the decoded instruction.
  - R-type and I-type go to WB.
  - STUR and LDUR (o_SEU = 1, add) go to MEM.
  - B: assert o_pcWr with o_pcSrc = 1, then go to FETCH.
  - BL: same as B, and in the same cycle assert o_rfWr with o_wrDataSel = 2. The PC already holds PC+4, so that is the value written to the link register.
  - BR: assert o_pcWr with o_pcSrc = 2, then go to FETCH.
  - CBZ/CBNZ: o_reg2Sel = 1, o_ALUOp = 8. Taken when live i_Z = 1 (CBZ) or i_Z = 0 (CBNZ). Taken asserts o_pcWr with o_pcSrc = 1. Go to FETCH either way.
  - B.cond: evaluate the registered flags r_Z/r_N. EQ = 0000: Z. NE = 0001: !Z. GE = 1010: !N. LT = 1011: N. GT = 1100: !Z & !N. LE = 1101: Z | N. AL = 1110: always taken. Every other code is not taken.
- **MEM**: o_memAddrSel = 1. LDUR holds o_memRd, and STUR holds o_memWr with o_reg2Sel = 1, until i_memReady. Then LDUR goes to WB and STUR goes to FETCH.
- **WB**: assert o_rfWr. o_wrDataSel = 0 for LDUR and 1 for everything else. Then go to FETCH.

Flags:
- r_Z and r_N load i_Z and i_N on the last EXEC cycle of SUBIS, ADDS and SUBS only.
- Reset clears both to 0.

## Timing
- Reset:
  - While i_rst is high, every output is 0.
  - On the first edge with i_rst high, state becomes FETCH, the flags clear and the timeout counter clears.
  - Reset takes effect from any state, including mid-wait in FETCH or MEM. No memory strobe is issued during reset.
- Instruction latency with zero-wait memory (i_memReady high on the first request cycle):
  - B, BL, BR, CB-type, B.cond: 3 cycles.
  - R-type, I-type, STUR: 4 cycles.
  - LDUR: 5 cycles.
  - Each memory wait cycle adds one cycle.
- All outputs decode combinationally from state and opcode (Moore with opcode qualification).
- o_irWr and o_pcWr are each high for exactly one cycle per event.
- An i_memReady seen outside FETCH and MEM is ignored.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - A counter runs while the sequencer waits in FETCH or MEM and clears on state exit.
  - When it reaches TIMEOUT_CYCLES with no i_memReady, o_memErr pulses for one cycle and the state returns to FETCH.
  - A store that times out is not retried. No RF or PC write occurs for the aborted instruction.
- SEQ_MEM_TIMEOUT_EN undefined: no counter, the sequencer waits indefinitely, and o_memErr is constant 0.

## Test plan
- ADD with i_memReady tied high: o_state sequence 0, 1, 2, 4, 0. o_ALUOp = 0 in EXEC. o_rfWr = 1 and o_wrDataSel = 1 in WB only.
- LDUR with i_memReady low for 2 MEM cycles: MEM lasts 3 cycles with o_memRd high. WB has o_wrDataSel = 0. Total 7 cycles.
- SUBIS with i_Z = 1, then B.cond EQ with live i_Z = 0: branch taken (o_pcWr = 1, o_pcSrc = 1). The same sequence with B.cond NE: not taken.
- BL: in the EXEC cycle, o_pcWr = 1, o_pcSrc = 1, o_rfWr = 1 and o_wrDataSel = 2, all together. Next state is FETCH.
- Opcode 11'h000: o_illegal pulses in DECODE, next state is FETCH, and there is no RF or PC write.
- With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 16, i_memReady held low in FETCH: o_memErr pulses at the 16th wait cycle, then FETCH restarts. Asserting i_rst mid-wait gives all outputs 0 and state FETCH on the next edge.
